problema1_scan_ctrl: RTL and testbench
======================================

// Module: problema1_scan_ctrl
// PURPOSE
//  Avalon-MM slave that sequences the LED-matrix row/column drive lines under software control.
//  Software writes a ROWS x COLS image into a back buffer; the block scans it row by row, one-hot.
//  A blanking gap separates rows. A front/back swap happens only at frame end, so no frame tears.
//  Sits on the Nios II bus beside the PIO slaves and drives the matrix pins directly.
// PARAMETERS
//  ROWS       5     matrix rows (legal 1..5); row addresses 0..ROWS-1
//  COLS       7     matrix columns (legal 1..32)
//  DWELL_W    16    width of dwell-time register
//  BLANK_CYC  4     clk cycles all-off between rows (>=1)
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        reset, asynchronous, active-low
//  address     in   3        word address
//  chipselect  in   1        slave select
//  write_n     in   1        active-low write strobe
//  writedata   in   32       write data
//  readdata    out  32       read data; combinational from address, zero-extended
//  linhas_out  out  ROWS     row drive, one-hot while driving, else 0
//  colunas_out out  COLS     column data for the active row, else 0
//  frame_irq   out  1        irq_flag & irq_en
// BEHAVIOUR
//  Register map (write = chipselect & ~write_n):
//   0..ROWS-1  back[row][COLS-1:0], read/write; other addresses below 5 read 0, writes ignored
//   5  ctrl: b0 enable, b1 swap_req (write 1 sets swap_pending; writing 0 has no effect), b2 irq_en
//      read returns {irq_en, swap_pending, enable}
//   6  dwell[DWELL_W-1:0]: drive cycles per row; value 0 behaves as 1
//   7  status: read {frame_cnt[7:0] at 15:8, irq_flag at 0}; write b0=1 clears irq_flag
//  Reset: outputs 0, front/back 0, ctrl 0, swap_pending 0, dwell=1000, frame_cnt 0, irq_flag 0
//  FSM IDLE/BLANK/DRIVE; row_idx 0..ROWS-1; one shared cycle counter
//   IDLE : outputs 0, row_idx=0. Goes to BLANK on the next clk after enable is seen at 1.
//   BLANK: outputs 0 for exactly BLANK_CYC cycles, then DRIVE.
//   DRIVE: linhas_out=1<<row_idx, colunas_out=front[row_idx] for max(dwell,1) cycles.
//          On its last cycle:
//          - row_idx<ROWS-1: row_idx++.
//          - otherwise frame end: row_idx=0; frame_cnt++ (wraps 255->0); irq_flag=1.
//            If swap_pending: front<=back and clear swap_pending.
//          Then go to BLANK.
//  Outputs are registered: one clk latency from state change to pins.
//  Dwell register is sampled when entering DRIVE; a write mid-row takes effect on the next row.
//  Enable cleared in any state: IDLE on the next clk, outputs 0 that clk, row_idx=0.
//   swap_pending, front, frame_cnt and irq_flag are kept.
//  Simultaneous events:
//   - Back-buffer write in the frame-end cycle: copy uses the old back value; the write lands in back.
//   - swap_req write in the frame-end cycle: the swap uses the old pending value; pending is then set.
//   - irq_flag set and clear in the same cycle: set wins.
//  ROWS=1: every DRIVE end is a frame end.
// TESTING
//  1 Reset, write back rows 0..4 = 7'h01,02,04,08,10, dwell=3, ctrl=3 -> after the first frame end the
//    pins show linhas 5'b00001 / colunas 7'h01 for 3 clk; 4 clk all-zero between rows; row 4 -> row 0 wraps.
//  2 Enabled with no swap_req, rewrite back rows -> pins unchanged over 3 full frames; frame_cnt +3.
//  3 Write swap_req in the exact frame-end cycle -> no swap that frame; swap at the next frame end;
//    ctrl b1 reads 0 after.
//  4 irq_en=1 -> frame_irq rises 1 clk after frame end; status write 1 clears it; clear in a
//    frame-end cycle leaves it at 1.
//  5 Clear enable mid-DRIVE of row 2 -> pins 0 next clk; re-enable -> scan restarts at row 0 after BLANK_CYC.
//  6 dwell=0 -> each row driven 1 clk; assert reset_n mid-frame -> all outputs 0 immediately; dwell reads 1000.

Source files
------------

// File: rtl/problema1_scan_ctrl.sv
// LED-matrix scan controller on an Avalon-MM slave: double-buffered image,
// one-hot row scan with a blanking gap, tear-free buffer swap at frame end.
module problema1_scan_ctrl #(
   parameter int ROWS      = 5,
   parameter int COLS      = 7,
   parameter int DWELL_W   = 16,
   parameter int BLANK_CYC = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ROWS-1:0]   linhas_out,
   output logic [COLS-1:0]   colunas_out,
   output logic              frame_irq
);

   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BW    = $clog2(BLANK_CYC + 1);
   localparam int CNT_W = (DWELL_W > BW) ? DWELL_W : BW;
   localparam logic [CNT_W-1:0]   CNT_ONE    = 1;
   localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [RW-1:0]      ROW_LAST   = RW'(ROWS - 1);
   localparam logic [DWELL_W-1:0] DWELL_RST  = DWELL_W'(1000);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]        row_q, row_d;
   logic [DWELL_W-1:0]   dwell_lat_q, dwell_lat_d;
   logic                 frame_end;

   logic                 enable_q, irq_en_q, swap_pend_q, irq_flag_q;
   logic [DWELL_W-1:0]   dwell_q;
   logic [7:0]           frame_cnt_q;
   logic [COLS-1:0]      back_q  [ROWS];
   logic [COLS-1:0]      front_q [ROWS];
   logic [ROWS-1:0]      linhas_q, linhas_d;
   logic [COLS-1:0]      colunas_q, colunas_d;
   logic [COLS-1:0]      front_sel;

   logic wr, wr_ctrl, wr_dwell, wr_stat;
   logic unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wr_ctrl   = wr && (address == 3'd5);
   assign wr_dwell  = wr && (address == 3'd6);
   assign wr_stat   = wr && (address == 3'd7);
   assign unused_wd = ^writedata;

   // FSM state register plus the shared cycle counter and the latched dwell
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         dwell_lat_q <= DWELL_W'(1);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         dwell_lat_q <= dwell_lat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      dwell_lat_d = dwell_lat_q;
      frame_end   = 1'b0;
      if (!enable_q) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               cnt_d   = '0;
               row_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d     = S_DRIVE;
                  cnt_d       = '0;
                  dwell_lat_d = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_DRIVE: begin
               if (cnt_q == (CNT_W'(dwell_lat_q) - CNT_ONE)) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  if (row_q == ROW_LAST) begin
                     row_d     = '0;
                     frame_end = 1'b1;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      front_sel = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == RW'(r)) front_sel = front_q[r];
      end
   end

   // Pins follow the current state, so they lag the state by one clock
   always_comb begin
      linhas_d  = '0;
      colunas_d = '0;
      if (enable_q && state_q == S_DRIVE) begin
         linhas_d  = ROWS'(1) << row_q;
         colunas_d = front_sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         linhas_q  <= '0;
         colunas_q <= '0;
      end else begin
         linhas_q  <= linhas_d;
         colunas_q <= colunas_d;
      end
   end

   // Copy reads the pre-edge back value, so a same-cycle write lands only in back
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < ROWS; r++) begin
            back_q[r]  <= '0;
            front_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (frame_end && swap_pend_q) front_q[r] <= back_q[r];
            if (wr && address == 3'(r))   back_q[r]  <= writedata[COLS-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         swap_pend_q <= 1'b0;
         irq_flag_q  <= 1'b0;
         dwell_q     <= DWELL_RST;
         frame_cnt_q <= '0;
      end else begin
         if (wr_ctrl) begin
            enable_q <= writedata[0];
            irq_en_q <= writedata[2];
         end
         // A swap request in the frame-end cycle survives for the next frame
         if (wr_ctrl && writedata[1])
            swap_pend_q <= 1'b1;
         else if (frame_end)
            swap_pend_q <= 1'b0;
         if (frame_end)
            irq_flag_q <= 1'b1;
         else if (wr_stat && writedata[0])
            irq_flag_q <= 1'b0;
         if (wr_dwell)
            dwell_q <= writedata[DWELL_W-1:0];
         if (frame_end)
            frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   always_comb begin
      readdata = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (address == 3'(r)) readdata[COLS-1:0] = back_q[r];
      end
      case (address)
         3'd5:    readdata[2:0] = {irq_en_q, swap_pend_q, enable_q};
         3'd6:    readdata[DWELL_W-1:0] = dwell_q;
         3'd7: begin
            readdata[15:8] = frame_cnt_q;
            readdata[0]    = irq_flag_q;
         end
         default: ;
      endcase
   end

   assign linhas_out  = linhas_q;
   assign colunas_out = colunas_q;
   assign frame_irq   = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_problema1_scan_ctrl.sv
// Directed bench for problema1_scan_ctrl: scan timing, buffer swap,
// interrupt flag, enable/disable and asynchronous reset.
module tb_problema1_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [4:0]  linhas_out;
   logic [6:0]  colunas_out;
   logic        frame_irq;

   int n_vec = 0;
   int n_err = 0;
   int dwell_exp = 3;
   logic [6:0] old_cols [5];
   logic [6:0] new_cols [5];

   problema1_scan_ctrl #(.ROWS(5), .COLS(7), .DWELL_W(16), .BLANK_CYC(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .linhas_out  (linhas_out),
      .colunas_out (colunas_out),
      .frame_irq   (frame_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
   endtask

   task automatic chk_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   task automatic chk_pins_zero(input string tag);
      chk({tag, "_lin"}, 32'(linhas_out), 32'd0);
      chk({tag, "_col"}, 32'(colunas_out), 32'd0);
   endtask

   // Starts on the edge where the row enters DRIVE; ends on the next such edge
   task automatic check_row(input int r, input logic [6:0] col, input int wr_at,
                            input logic [2:0] wa, input logic [31:0] wd, input bit irq_chk);
      logic [4:0] e;
      e = 5'b00001 << r;
      for (int t = 0; t < dwell_exp; t++) begin
         if (t == wr_at) begin
            address = wa; writedata = wd; chipselect = 1'b1; write_n = 1'b0;
         end
         tick();
         chk($sformatf("row%0d_t%0d_lin", r, t), 32'(linhas_out), 32'(e));
         chk($sformatf("row%0d_t%0d_col", r, t), 32'(colunas_out), 32'(col));
         if (irq_chk)
            chk($sformatf("row%0d_t%0d_irq", r, t), 32'(frame_irq), 32'(r == 4 && t == dwell_exp - 1));
      end
      for (int t = 0; t < 4; t++) begin
         tick();
         chk_pins_zero($sformatf("row%0d_blank%0d", r, t));
         if (irq_chk)
            chk($sformatf("row%0d_blank%0d_irq", r, t), 32'(frame_irq), 32'(r == 4));
      end
   endtask

   task automatic check_frame(input bit use_new, input bit zeros);
      logic [6:0] c;
      for (int r = 0; r < 5; r++) begin
         c = zeros ? 7'h00 : (use_new ? new_cols[r] : old_cols[r]);
         check_row(r, c, -1, 3'd0, 32'd0, 1'b0);
      end
   endtask

   initial begin
      old_cols[0] = 7'h01; old_cols[1] = 7'h02; old_cols[2] = 7'h04;
      old_cols[3] = 7'h08; old_cols[4] = 7'h10;
      new_cols[0] = 7'h7F; new_cols[1] = 7'h3F; new_cols[2] = 7'h1F;
      new_cols[3] = 7'h0F; new_cols[4] = 7'h07;
      reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

      // Reset state
      repeat (3) tick();
      chk_pins_zero("rst");
      chk("rst_irq", 32'(frame_irq), 32'd0);
      chk_read("rst_ctrl", 3'd5, 32'd0);
      chk_read("rst_dwell", 3'd6, 32'd1000);
      chk_read("rst_status", 3'd7, 32'd0);
      chk_read("rst_back4", 3'd4, 32'd0);
      reset_n = 1'b1;
      tick();

      // Load image, dwell=3, enable with swap request
      for (int r = 0; r < 5; r++) bus_write(3'(r), 32'(old_cols[r]));
      bus_write(3'd6, 32'd3);
      chk_read("back2_rd", 3'd2, 32'h04);
      chk_read("dwell_rd", 3'd6, 32'd3);
      bus_write(3'd5, 32'd3);
      repeat (5) tick();
      chk_pins_zero("first_blank");
      chk_read("ctrl_pending", 3'd5, 32'd3);
      check_frame(1'b0, 1'b1);
      chk_read("status_f1", 3'd7, 32'h0101);
      chk_read("ctrl_swapped", 3'd5, 32'd1);
      check_frame(1'b0, 1'b0);

      // Rewrite back without swap_req: pins unchanged for three frames
      for (int r = 0; r < 5; r++) check_row(r, old_cols[r], 0, 3'(r), 32'(new_cols[r]), 1'b0);
      check_frame(1'b0, 1'b0);
      check_frame(1'b0, 1'b0);
      chk_read("status_f5", 3'd7, 32'h0501);
      chk_read("back0_new", 3'd0, 32'h7F);

      // swap_req landing exactly on the frame-end edge
      for (int r = 0; r < 4; r++) check_row(r, old_cols[r], -1, 3'd0, 32'd0, 1'b0);
      check_row(4, old_cols[4], 2, 3'd5, 32'd3, 1'b0);
      chk_read("ctrl_late_req", 3'd5, 32'd3);
      check_frame(1'b0, 1'b0);
      chk_read("ctrl_after_swap", 3'd5, 32'd1);
      check_frame(1'b1, 1'b0);
      chk_read("status_f8", 3'd7, 32'h0801);

      // Interrupt enable, clear, and clear colliding with frame end
      check_row(0, new_cols[0], 0, 3'd5, 32'd5, 1'b0);
      chk("irq_en_on", 32'(frame_irq), 32'd1);
      check_row(1, new_cols[1], 0, 3'd7, 32'd1, 1'b1);
      check_row(2, new_cols[2], -1, 3'd0, 32'd0, 1'b1);
      check_row(3, new_cols[3], -1, 3'd0, 32'd0, 1'b1);
      check_row(4, new_cols[4], 2, 3'd7, 32'd1, 1'b1);
      chk_read("status_f9", 3'd7, 32'h0901);

      // Disable during DRIVE of row 2, then re-enable
      check_row(0, new_cols[0], -1, 3'd0, 32'd0, 1'b0);
      check_row(1, new_cols[1], -1, 3'd0, 32'd0, 1'b0);
      address = 3'd5; writedata = 32'd4; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chk("dis_row2_lin", 32'(linhas_out), 32'h04);
      chk("dis_row2_col", 32'(colunas_out), 32'(new_cols[2]));
      tick();
      chk_pins_zero("dis_next");
      repeat (3) tick();
      chk_pins_zero("dis_idle");
      chk_read("ctrl_dis", 3'd5, 32'd4);
      chk_read("status_dis", 3'd7, 32'h0901);
      bus_write(3'd5, 32'd5);
      repeat (5) tick();
      chk_pins_zero("reen_blank");
      check_frame(1'b1, 1'b0);
      chk_read("status_reen", 3'd7, 32'h0A01);

      // dwell=0 drives each row for one clock; then asynchronous reset mid-frame
      bus_write(3'd5, 32'd4);
      bus_write(3'd6, 32'd0);
      chk_read("dwell_zero", 3'd6, 32'd0);
      bus_write(3'd5, 32'd5);
      repeat (5) tick();
      chk_pins_zero("d0_blank");
      dwell_exp = 1;
      check_frame(1'b1, 1'b0);
      tick();
      chk("pre_rst_lin", 32'(linhas_out), 32'h01);
      chk("pre_rst_col", 32'(colunas_out), 32'h7F);
      reset_n = 1'b0;
      #1;
      chk_pins_zero("async_rst");
      chk("async_rst_irq", 32'(frame_irq), 32'd0);
      chk_read("async_rst_dwell", 3'd6, 32'd1000);
      chk_read("async_rst_status", 3'd7, 32'd0);
      chk_read("async_rst_back0", 3'd0, 32'd0);
      reset_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
